// File: rtl/pkt_pkg.sv
// Shared packet-path types: word layout, arbiter states, packet struct.
// Imported by the arbiter and its helpers.
package pkt_pkg;

  localparam int PKT_W       = 13;
  localparam int DST_LSB     = 11;
  localparam int TYPE_LSB    = 9;
  localparam int PAYLOAD_LSB = 1;
  localparam int EOP_BIT     = 0;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef struct packed {
    logic [1:0] dst_addr;
    logic [1:0] pack_t;
    logic [7:0] payload;
    logic       eop;
  } pkt_t;

endpackage

// File: rtl/pkt_arbiter_rr_pick.sv
// Round-robin select: first req at or above ptr, wrapping modulo N.
// Ports: req (N), ptr (PW) in; one-hot gnt (N), any out.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pkt_arbiter.sv
// Packet-atomic round-robin arbiter with length watchdog.
// Ports: clk, reset (async, low); src_pkt/valid/ready; out_pkt/valid/ready; grant; err_overrun.
module pkt_arbiter #(
  parameter int N_SRC     = 4,
  parameter int PKT_W     = pkt_pkg::PKT_W,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SRC-1:0][PKT_W-1:0] src_pkt,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [N_SRC-1:0]            src_ready,
  output logic [PKT_W-1:0]            out_pkt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_SRC-1:0]            grant,
  output logic                        err_overrun
);
  import pkt_pkg::*;

  localparam int PW = $clog2(N_SRC);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    rr_ptr, gidx;
  logic [7:0]       beat_cnt;
  logic [N_SRC-1:0] win;
  logic             any_req;
  logic [PKT_W-1:0] sel_pkt, load_pkt;
  logic             out_free, accept;
  logic             sel_eop, wd_hit, pkt_end;

  rr_pick #(
    .N  (N_SRC),
    .PW (PW)
  ) u_pick (
    .req (src_valid),
    .ptr (rr_ptr),
    .gnt (win),
    .any (any_req)
  );

  assign out_free  = !out_valid || out_ready;
  assign src_ready = (state_q == ARB_BUSY && out_free)
                   ? grant : '0;
  assign accept    = |(src_valid & src_ready);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_SRC; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign sel_pkt = src_pkt[gidx];
  assign sel_eop = sel_pkt[EOP_BIT];
  // beat_cnt counts beats already taken, so this is the MAX_BEATS-th
  assign wd_hit  = accept && !sel_eop
                && (beat_cnt == 8'(MAX_BEATS - 1));
  assign pkt_end = accept && (sel_eop || wd_hit);

  // truncated packets are closed by forcing eop on the last beat
  always_comb begin
    load_pkt          = sel_pkt;
    load_pkt[EOP_BIT] = sel_eop | wd_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_BUSY;
      ARB_BUSY: if (pkt_end) state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      out_pkt     <= '0;
      out_valid   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= wd_hit;
      if (state_q == ARB_IDLE && any_req) begin
        grant    <= win;
        beat_cnt <= '0;
      end
      if (accept) begin
        out_pkt   <= load_pkt;
        out_valid <= 1'b1;
        beat_cnt  <= beat_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pkt_end) begin
        grant  <= '0;
        rr_ptr <= (gidx == PW'(N_SRC - 1))
                ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Scoreboard bench for pkt_arbiter: packet-level round-robin reference
// model predicts grant order, output words and watchdog truncations.
module tb_pkt_arbiter;
  import pkt_pkg::*;

  localparam int NS = 4;
  localparam int MB = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NS-1:0][12:0] src_pkt;
  logic [NS-1:0]       src_valid;
  logic [NS-1:0]       src_ready;
  logic [12:0]         out_pkt;
  logic                out_valid;
  logic                out_ready;
  logic [NS-1:0]       grant;
  logic                err_overrun;

  pkt_arbiter #(
    .N_SRC     (NS),
    .PKT_W     (13),
    .MAX_BEATS (MB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_pkt     (src_pkt),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .out_pkt     (out_pkt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  logic [12:0]   src_q [NS][$];
  logic [12:0]   exp_q [$];
  int            exp_gnt [$];
  logic [NS-1:0] acc;
  int n_chk = 0, n_fail = 0;
  int mdl_ptr = 0, exp_ovr = 0, ovr_seen = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_word(input int s, input logic [7:0] pl,
                          input logic e);
    pkt_t p;
    p.dst_addr = 2'($urandom_range(0, 3));
    p.pack_t   = 2'($urandom_range(0, 3));
    p.payload  = pl;
    p.eop      = e;
    src_q[s].push_back(p);
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++)
      add_word(s, 8'($urandom()), (b == len - 1));
  endtask

  // Packet-level model: serve non-empty sources round-robin, each
  // packet ends at eop or after MB beats (last beat forced to eop).
  task automatic build_model();
    logic [12:0] cq [NS][$];
    logic [12:0] w;
    int g, n, idx;
    bit found;
    for (int i = 0; i < NS; i++) cq[i] = src_q[i];
    while (1) begin
      found = 0;
      g = 0;
      for (int k = 0; k < NS; k++) begin
        idx = (mdl_ptr + k) % NS;
        if (!found && cq[idx].size() > 0) begin
          g = idx;
          found = 1;
        end
      end
      if (!found) break;
      exp_gnt.push_back(g);
      n = 0;
      while (1) begin
        w = cq[g].pop_front();
        n++;
        if (w[0]) begin
          exp_q.push_back(w);
          break;
        end
        if (n == MB) begin
          exp_q.push_back(w | 13'h1);
          exp_ovr++;
          break;
        end
        exp_q.push_back(w);
      end
      mdl_ptr = (g + 1) % NS;
    end
  endtask

  task automatic drive_cycle(input int mode, input bit stall,
                             input int cyc);
    bit has;
    @(negedge clk);
    for (int i = 0; i < NS; i++)
      if (acc[i]) void'(src_q[i].pop_front());
    for (int i = 0; i < NS; i++) begin
      has = src_q[i].size() > 0;
      src_valid[i] = has &&
        !(stall && grant[i] && $urandom_range(0, 3) == 0);
      src_pkt[i] = has ? src_q[i][0] : 13'h0;
    end
    case (mode)
      1:       out_ready = ($urandom_range(0, 9) < 7);
      2:       out_ready = !(cyc >= 3 && cyc <= 7);
      default: out_ready = 1'b1;
    endcase
    #4;
    acc = src_valid & src_ready;
  endtask

  function automatic bit pending();
    bit p = exp_q.size() > 0;
    for (int i = 0; i < NS; i++)
      if (src_q[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic run_phase(input int mode, input bit stall,
                           input int budget);
    int cyc = 0;
    build_model();
    while (pending() && cyc < budget) begin
      drive_cycle(mode, stall, cyc);
      cyc++;
    end
    repeat (4) drive_cycle(0, 0, 0);
    chk("exp_drained", exp_q.size(), 0);
    chk("grant_drained", exp_gnt.size(), 0);
    chk("overrun_count", ovr_seen, exp_ovr);
  endtask

  // Monitor: samples just before each rising edge.
  bit          prev_stall;
  logic [12:0] prev_pkt;
  logic [NS-1:0] prev_gnt;
  always begin
    int g;
    @(negedge clk);
    #4;
    if (!mon_en) begin
      prev_stall = 0;
      prev_gnt   = '0;
    end else begin
      chk("grant_onehot", 32'($onehot0(grant)), 1);
      if (grant != 0 && prev_gnt == 0) begin
        if (exp_gnt.size() == 0)
          chk("grant_unexpected", 32'(grant), 0);
        else begin
          g = exp_gnt.pop_front();
          chk("grant_order", 32'(grant), 32'(1 << g));
        end
      end
      if (prev_stall) begin
        chk("bp_hold_valid", 32'(out_valid), 1);
        chk("bp_hold_pkt", 32'(out_pkt), 32'(prev_pkt));
      end
      if (out_valid && !out_ready)
        chk("bp_src_ready", 32'(src_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("beat_unexpected", exp_q.size(), 1);
        else
          chk("beat", 32'(out_pkt), 32'(exp_q.pop_front()));
      end
      if (err_overrun) ovr_seen++;
      prev_stall = out_valid && !out_ready;
      prev_pkt   = out_pkt;
      prev_gnt   = grant;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    reset = 1'b0;
    src_valid = '0;
    src_pkt = '0;
    out_ready = 1'b0;
    acc = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pkt", 32'(out_pkt), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_src_ready", 32'(src_ready), 0);
    reset = 1'b1;
    mon_en = 1;

    add_word(0, 8'h11, 1'b0);
    add_word(0, 8'h22, 1'b0);
    add_word(0, 8'h33, 1'b1);
    run_phase(0, 0, 50);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++) add_pkt(i, 1);
    run_phase(0, 0, 100);

    add_pkt(0, 4);
    add_pkt(2, 2);
    run_phase(2, 0, 100);

    for (int b = 0; b < 6; b++)
      add_word(2, 8'($urandom()), (b == 5));
    add_pkt(0, 1);
    add_pkt(3, 1);
    run_phase(0, 0, 100);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--)
          add_pkt(i, $urandom_range(1, 6));
      run_phase(1, 1, 2000);
    end

    mon_en = 0;
    add_pkt(1, 3);
    cnt = 0;
    for (int c = 0; c < 20 && cnt == 0; c++) begin
      drive_cycle(0, 0, 0);
      if (acc[1]) cnt++;
    end
    chk("ar_first_beat", cnt, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_pkt", 32'(out_pkt), 0);
    chk("ar_grant", 32'(grant), 0);
    chk("ar_src_ready", 32'(src_ready), 0);
    chk("ar_err", 32'(err_overrun), 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    exp_gnt.delete();
    acc = '0;
    src_valid = '0;
    mdl_ptr = 0;
    exp_ovr = 0;
    ovr_seen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1;
    add_pkt(3, 2);
    add_pkt(1, 2);
    run_phase(0, 0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
